// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and constants for the BCD conversion arbiter
// Contents: FSM state encoding, BCD digit width, double-dabble add-3 constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] ADD3_THRESH = DIGIT_W'(5);
   localparam logic [DIGIT_W-1:0] ADD3_VAL    = DIGIT_W'(3);

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one combinational double-dabble step (add-3 then shift)
// Ports:
//   din   in   {digits, operand msb}; digits are DIGITS packed BCD nibbles
//   dout  out  digits after add-3 correction and a one-bit left shift
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic [DIGIT_W*DIGITS:0]   din,
   output logic [DIGIT_W*DIGITS-1:0] dout
);

   localparam int BCD_W = DIGIT_W * DIGITS;

   logic [BCD_W-1:0] digits;
   logic [BCD_W-1:0] adj;

   assign digits = din[BCD_W:1];

   // A digit >= 5 would become >= 10 after doubling; adding 3 first makes
   // the doubled value carry correctly into the next nibble.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digits[i*DIGIT_W +: DIGIT_W] >= ADD3_THRESH)
            adj[i*DIGIT_W +: DIGIT_W] = digits[i*DIGIT_W +: DIGIT_W] + ADD3_VAL;
         else
            adj[i*DIGIT_W +: DIGIT_W] = digits[i*DIGIT_W +: DIGIT_W];
      end
   end

   // The operand msb enters at the bottom of the ones digit.
   assign dout = {adj[BCD_W-2:0], din[0]};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin shared sequential binary-to-BCD converter
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req0/bin0        requester 0 level request and operand
//   req1/bin1        requester 1 level request and operand
//   ack0/ack1        one-cycle pulse: bcd_out holds the served requester's result
//   bcd_valid        ack0 | ack1
//   owner            requester index of the current bcd_out contents
//   bcd_out          {hundreds, tens, ones}
//   busy             conversion in progress (SHIFT or DONE)
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0,
   input  logic [WIDTH-1:0]          bin0,
   input  logic                      req1,
   input  logic [WIDTH-1:0]          bin1,
   output logic                      ack0,
   output logic                      ack1,
   output logic                      bcd_valid,
   output logic                      owner,
   output logic [DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                      busy
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   bcd_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] opnd, opnd_n;
   logic [BCD_W-1:0] digits, digits_n;
   logic [BCD_W-1:0] step_out;
   logic [BCD_W-1:0] bcd_n;
   logic             owner_n;
   logic             ack0_n, ack1_n;
   logic             cur, cur_n;          // requester being served right now
   logic             last_grant, last_grant_n;
   logic             sel;

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .din  ({digits, opnd[WIDTH-1]}),
      .dout (step_out)
   );

   // On a tie the requester that was not served last wins.
   assign sel = (req0 && req1) ? ~last_grant : req1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         opnd       <= '0;
         digits     <= '0;
         bcd_out    <= '0;
         owner      <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         bcd_valid  <= 1'b0;
         cur        <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         opnd       <= opnd_n;
         digits     <= digits_n;
         bcd_out    <= bcd_n;
         owner      <= owner_n;
         ack0       <= ack0_n;
         ack1       <= ack1_n;
         bcd_valid  <= ack0_n | ack1_n;
         cur        <= cur_n;
         last_grant <= last_grant_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      opnd_n       = opnd;
      digits_n     = digits;
      bcd_n        = bcd_out;
      owner_n      = owner;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      cur_n        = cur;
      last_grant_n = last_grant;

      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               opnd_n       = sel ? bin1 : bin0;
               digits_n     = '0;
               cnt_n        = CNT_LOAD;
               cur_n        = sel;
               last_grant_n = sel;
               state_n      = SHIFT;
            end
         end
         SHIFT: begin
            digits_n = step_out;
            opnd_n   = {opnd[WIDTH-2:0], 1'b0};
            cnt_n    = cnt - 1'b1;
            // The last shift goes straight into the output register so the
            // result and its ack appear together.
            if (cnt == CNT_LAST) begin
               bcd_n   = step_out;
               owner_n = cur;
               ack0_n  = ~cur;
               ack1_n  = cur;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shares one sequential double-dabble binary-to-BCD engine between two requesters. In the temperature display path these are the DS18B20 temperature byte and the alarm-threshold byte. The block arbitrates round-robin, converts one bit per clock, and returns a registered three-digit BCD result with a one-cycle acknowledge to the requester that was served. It sits between the sensor/threshold logic and the 74HC595 display driver.

## Interface
- WIDTH, 8, binary operand width.
- DIGITS, 3, BCD output digits. 10^DIGITS must exceed 2^WIDTH-1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 conversion request, level-sensitive.
- bin0  in  WIDTH  requester 0 operand.
- req1  in  1  requester 1 conversion request, level-sensitive.
- bin1  in  WIDTH  requester 1 operand.
- ack0  out  1  one-cycle pulse: result for requester 0 valid on bcd_out.
- ack1  out  1  one-cycle pulse: result for requester 1 valid on bcd_out.
- bcd_valid  out  1  one-cycle pulse, equal to ack0|ack1.
- owner  out  1  requester index of the current bcd_out contents.
- bcd_out  out  4*DIGITS  {hundreds, tens, ones}, most significant digit in the top nibble.
- busy  out  1  high in SHIFT and DONE.

## Operation
- Reset values: all outputs 0, state IDLE, last_grant=1 so req0 wins the first tie.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: if any req is high, grant it. If both are high, grant the one not equal to last_grant. On grant, latch the selected bin into the operand shift register, clear the BCD digit registers, set bit counter=WIDTH, record owner_next and last_grant, and go to SHIFT. With no req, stay in IDLE.
  - SHIFT, each cycle:
    - Add 3 to every digit that is >=5.
    - Shift {digits, operand} left by one.
    - Decrement the counter.
    - When the counter reaches 1, the final shift loads bcd_out, sets owner, asserts ackN/bcd_valid, and moves to DONE.
  - DONE: ack and bcd_valid high for exactly this cycle, then go to IDLE. No grant is made in DONE.
- Handshake:
  - A requester holds req until its ack.
  - bin is sampled only at the grant edge; later changes are ignored.
  - A req dropped before grant is not served.
  - A req still high after its ack is treated as a new request. Round-robin lets the other requester in first if it is waiting.
- Digit arithmetic:
  - Each digit is 4 bits. The add-3 is applied before the shift.
  - A digit never exceeds 9 after any shift.
  - No overflow is possible under the DIGITS rule.
- bcd_out and owner hold their last values until the next DONE.
- A reset mid-SHIFT or mid-DONE:
  - abandons the conversion with no ack;
  - returns all outputs to 0, the state to IDLE and last_grant to 1.

## Timing
- E0 is the grant edge in IDLE. Shifts happen at E1..E(WIDTH).
- At E(WIDTH), bcd_out, owner, ack and bcd_valid update. They are high in the cycle after E(WIDTH), which is E8 for WIDTH=8.
- At E(WIDTH+1), the state returns to IDLE and ack drops. The earliest next grant is at E(WIDTH+2).
- Throughput is one conversion per WIDTH+2 cycles: 10 for the defaults.
- Both requesters held continuously are served alternately, 0,1,0,1…
- All outputs are registered, with no combinational path from req or bin to any output.

## Structure
- Shared package bcd_pkg holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - DIGIT_W=4;
  - ADD3_THRESH=5 and ADD3_VAL=3.
- Sub-module bcd_dabble_step is combinational: it takes {digits, operand msb}, applies add-3 to each digit and returns the shifted digits. It is instantiated once in SHIFT.
- Arbiter, FSM, counter and output registers live in the top level, bcd_conv_arbiter.

## Test plan
- req0=1, bin0=8'd173, req1=0 after reset -> ack0 one cycle after E8, bcd_out=12'h173, owner=0, busy high for 9 cycles, ack1 never high.
- Boundaries on requester 1: bin1=8'd255 -> 12'h255; bin1=8'd0 -> 12'h000; bin1=8'd9 -> 12'h009; bin1=8'd10 -> 12'h010. Each has ack1 and owner=1.
- req0 and req1 both high from reset, bin0=8'd25, bin1=8'd100 -> ack0 with 12'h025, then ack1 with 12'h100 ten cycles later, then alternating while both are held.
- Grant req0 with bin0=8'd42, then change bin0 to 8'd99 at E3 -> result 12'h042.
- rst pulsed at E4 of a conversion -> no ack, busy=0, bcd_out=0, owner=0. A subsequent req1 with bin1=8'd7 completes normally with 12'h007.
- req1 held continuously with req0 low -> ack1 every 10 cycles and bcd_valid mirrors ack1.
